rv32i_if_id_buffer: RTL

Pipeline buffer between the instruction-fetch stage and the decode stage of the RV32I core. It captures each fetched PC/instruction pair in a 2-entry skid FIFO and presents the oldest entry to decode. It back-pressures fetch through a ready signal that drives the PC stall. A taken branch from MEM flushes the buffer and injects a NOP, so decode never sees a stale instruction.

---
 rtl/rv32i_if_id_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rv32i_if_id_buffer.sv
// rtl/rv32i_if_id_buffer.sv - IF/ID skid buffer: 2-entry FIFO, flush-to-NOP, optional perf counters (IFID_PERF_EN)
module rv32i_if_id_buffer #(
  parameter int REG_DATA_WIDTH  = 32,
  parameter int IMEM_ADDR_WIDTH = 32
) (
  input  logic                       Clk_100MHz,
  input  logic                       Reset,
  input  logic [IMEM_ADDR_WIDTH-1:0] IF_PC,
  input  logic [REG_DATA_WIDTH-1:0]  IF_Instruction,
  input  logic                       IF_valid,
  output logic                       IF_ready,
  input  logic                       MEM_PC_source_sel,
  input  logic                       ID_stall,
  output logic [IMEM_ADDR_WIDTH-1:0] ID_PC,
  output logic [REG_DATA_WIDTH-1:0]  ID_Instruction,
  output logic                       ID_valid
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]                Perf_stall_cycles,
  output logic [31:0]                Perf_flush_count
`endif
);

  localparam logic [REG_DATA_WIDTH-1:0] NOP_INSTR = REG_DATA_WIDTH'(32'h0000_0013);

  logic [IMEM_ADDR_WIDTH-1:0] pc_mem_q    [2];
  logic [REG_DATA_WIDTH-1:0]  instr_mem_q [2];

  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 count_q, count_d;

  logic                       id_valid_q, id_valid_d;
  logic [IMEM_ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [REG_DATA_WIDTH-1:0]  id_instr_q, id_instr_d;

  logic                       if_ready;
  logic                       push;
  logic                       pop;
  logic                       write_en;

  // Readiness is a pure function of occupancy so ID_stall never reaches fetch combinationally.
  assign if_ready = (count_q != 2'd2);

  // Pointer/count bookkeeping; a flush wins over any push or pop in the same cycle.
  always_comb begin
    push     = IF_valid & if_ready;
    pop      = id_valid_q & ~ID_stall;
    write_en = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (MEM_PC_source_sel) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      write_en = push;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Next head: when the new head slot is the one being written this edge, take it from the fetch inputs.
  always_comb begin
    id_valid_d = (count_d != 2'd0);
    id_pc_d    = '0;
    id_instr_d = NOP_INSTR;
    if (count_d != 2'd0) begin
      if (write_en && (rd_ptr_d == wr_ptr_q)) begin
        id_pc_d    = IF_PC;
        id_instr_d = IF_Instruction;
      end else begin
        id_pc_d    = pc_mem_q[rd_ptr_d];
        id_instr_d = instr_mem_q[rd_ptr_d];
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge Clk_100MHz) begin
    if (write_en) begin
      pc_mem_q[wr_ptr_q]    <= IF_PC;
      instr_mem_q[wr_ptr_q] <= IF_Instruction;
    end
  end

  // Control state and registered decode-side outputs.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign IF_ready       = if_ready;
  assign ID_valid       = id_valid_q;
  assign ID_PC          = id_pc_q;
  assign ID_Instruction = id_instr_q;

`ifdef IFID_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running wrap-around counters of fetch back-pressure cycles and flush cycles.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (IF_valid & ~if_ready) perf_stall_q <= perf_stall_q + 32'd1;
      if (MEM_PC_source_sel)    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign Perf_stall_cycles = perf_stall_q;
  assign Perf_flush_count  = perf_flush_q;
`endif

endmodule
